// File: rtl/tmr_serial_tx.sv
// tmr_serial_tx: UART-style frame serialiser driving three redundant lanes.
// Ports: clk, rst (sync, active-high), data/valid/ready handshake, busy,
//   lanes x2/x1/x0 (idle 1); with `TMR_FAULT_INJECT_EN defined, fault_en
//   and fault_lane (0=x0,1=x1,2=x2,3=none) invert one lane's data bits.
module tmr_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              busy,
  output logic              x2,
  output logic              x1,
  output logic              x0
`ifdef TMR_FAULT_INJECT_EN
  ,
  input  logic              fault_en,
  input  logic [1:0]        fault_lane
`endif
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              ready_q, busy_q;
  logic [2:0]        lanes_q, lanes_d;
  logic              bit_end;
  logic              line_d;
  logic [2:0]        flip;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_START;
          sh_d    = data;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          // index parks on the last bit; STOP does not use it
          if (idx_q == IDX_MAX) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Lane level for the cycle after this edge, so lanes are registered.
  always_comb begin
    line_d = 1'b1;
    unique case (state_d)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = sh_d[0];
      default: line_d = 1'b1;
    endcase
  end

`ifdef TMR_FAULT_INJECT_EN
  // Only data bits are ever corrupted; framing stays clean.
  always_comb begin
    flip = 3'b000;
    if (fault_en && (state_d == S_DATA)) begin
      unique case (fault_lane)
        2'd0:    flip = 3'b001;
        2'd1:    flip = 3'b010;
        2'd2:    flip = 3'b100;
        default: flip = 3'b000;
      endcase
    end
  end
`else
  assign flip = 3'b000;
`endif

  assign lanes_d = {3{line_d}} ^ flip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      lanes_q <= 3'b111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      lanes_q <= lanes_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign x2    = lanes_q[2];
  assign x1    = lanes_q[1];
  assign x0    = lanes_q[0];

endmodule

// File: tb/tb_tmr_serial_tx.sv
// tb_tmr_serial_tx: random + directed frames vs. a frame-timer model,
// plus a majority-vote receiver that decodes words off the lanes.
module tb_tmr_serial_tx;

  localparam int D  = 8;
  localparam int C  = 4;
  localparam int FR = (D + 2) * C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [D-1:0] data = '0;
  logic         valid = 1'b0;
  logic         ready, busy, x2, x1, x0;
`ifdef TMR_FAULT_INJECT_EN
  logic         fault_en = 1'b0;
  logic [1:0]   fault_lane = 2'd3;
`endif

  tmr_serial_tx #(.DATA_W(D), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .x2(x2), .x1(x1), .x0(x0)
`ifdef TMR_FAULT_INJECT_EN
    , .fault_en(fault_en), .fault_lane(fault_lane)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // model: frame in flight, cycles since handshake, captured word
  bit         m_busy = 0;
  int         m_t = 0;
  bit [D-1:0] m_word = '0;
  bit [2:0]   m_mask = '0;
  bit [D-1:0] hs_q[$];
  int         hs_cyc[$];

  // receiver on the voted lane
  bit         rx_on = 0;
  int         rx_t = 0;
  bit [D-1:0] rx_w = '0;
  bit [D-1:0] rx_q[$];
  int         starts[$];
  int         busy_cnt = 0;

  task automatic tick();
    logic v;
    bit lvl;
    bit [2:0] e;
    int b;
    @(posedge clk);
    cyc++;
    m_mask = '0;
`ifdef TMR_FAULT_INJECT_EN
    if (fault_en && fault_lane != 2'd3) m_mask[fault_lane] = 1'b1;
`endif
    if (rst) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == FR) m_busy = 0;
    end else if (valid) begin
      m_busy = 1;
      m_t = 0;
      m_word = data;
      hs_q.push_back(data);
      hs_cyc.push_back(cyc);
    end
    #1;
    lvl = 1'b1;
    e = 3'b000;
    if (m_busy) begin
      if (m_t < C) lvl = 1'b0;
      else if (m_t < (D + 1) * C) begin
        lvl = m_word[m_t / C - 1];
        e = m_mask;
      end
    end
    chk("cycle", {ready, busy, x2, x1, x0},
        {!m_busy, m_busy, ({3{lvl}} ^ e)});
    if (busy) busy_cnt++;
    v = (x2 & x1) | (x2 & x0) | (x1 & x0);
    if (rst) begin
      rx_on = 0;
    end else if (!rx_on) begin
      if (v == 1'b0) begin
        rx_on = 1;
        rx_t = 0;
        starts.push_back(cyc);
      end
    end else begin
      rx_t++;
      b = rx_t / C - 1;
      if (rx_t % C == C / 2 && b >= 0 && b < D) rx_w[b] = v;
      if (rx_t == (D + 1) * C + C / 2) begin
        chk("stop_bit", v, 1);
        rx_q.push_back(rx_w);
      end
      if (rx_t == FR - 1) rx_on = 0;
    end
  endtask

  task automatic clear();
    rx_q.delete();
    hs_q.delete();
    hs_cyc.delete();
    starts.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [D-1:0] w);
    valid = 1'b1;
    data = w;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    run(2);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lanes", {x2, x1, x0}, 3'b111);
    rst = 1'b0;
    run(20);
    chk("idle_lanes", {x2, x1, x0}, 3'b111);

    // single frame 0xA5
    clear();
    busy_cnt = 0;
    send(8'hA5);
    run(39);
    chk("a5_busy_last", busy, 1);
    tick();
    chk("a5_ready41", ready, 1);
    run(4);
    chk("a5_busy_cycles", busy_cnt, 40);
    chk("a5_nframes", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("a5_word", rx_q[0], 8'hA5);

    // valid during busy is ignored
    clear();
    send(8'h01);
    run(10);
    valid = 1'b1;
    data = 8'h3C;
    tick();
    valid = 1'b0;
    data = 8'hFF;
    run(60);
    chk("ign_nframes", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("ign_word", rx_q[0], 8'h01);

    // back-to-back with valid held
    clear();
    valid = 1'b1;
    data = 8'h55;
    tick();
    data = 8'hFF;
    for (int i = 0; i < 100 && hs_q.size() < 2; i++) tick();
    chk("b2b_hs_seen", hs_q.size(), 2);
    valid = 1'b0;
    run(45);
    chk("b2b_nframes", rx_q.size(), 2);
    if (starts.size() == 2) chk("b2b_pitch", starts[1] - starts[0], FR + 1);
    else chk("b2b_starts", starts.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_w0", rx_q[0], 8'h55);
      chk("b2b_w1", rx_q[1], 8'hFF);
    end

    // reset during data bit 3
    clear();
    send(8'hC3);
    run(17);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_ready", ready, 1);
    chk("rmid_lanes", {x2, x1, x0}, 3'b111);
    run(3);
    send(8'h0F);
    run(45);
    chk("rmid_nframes", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rmid_word", rx_q[0], 8'h0F);

    // reset and valid together: nothing captured
    rst = 1'b1;
    valid = 1'b1;
    data = 8'hAA;
    tick();
    rst = 1'b0;
    valid = 1'b0;
    tick();
    chk("rstv_busy", busy, 0);

`ifdef TMR_FAULT_INJECT_EN
    begin
      bit [D-1:0] w1, w0;
      clear();
      fault_en = 1'b1;
      fault_lane = 2'd1;
      send(8'hA5);
      for (int t = 1; t < FR + 4; t++) begin
        tick();
        if (t % C == C / 2 && t / C >= 1 && t / C <= D) begin
          w1[t / C - 1] = x1;
          w0[t / C - 1] = x0;
        end
      end
      chk("flt_x1", w1, 8'h5A);
      chk("flt_x0", w0, 8'hA5);
      chk("flt_nframes", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("flt_vote", rx_q[0], 8'hA5);
      fault_en = 1'b0;
      fault_lane = 2'd3;
    end
`endif

    // random frames, random gaps, junk valid while busy
    clear();
    for (int f = 0; f < 30; f++) begin
      int gap;
      send(D'($urandom));
      gap = $urandom_range(0, 5);
      for (int j = 0; j < FR + gap; j++) begin
        valid = (j < FR - 3) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        data = D'($urandom);
`ifdef TMR_FAULT_INJECT_EN
        fault_en = 1'($urandom);
        fault_lane = 2'($urandom);
`endif
        tick();
      end
    end
    valid = 1'b0;
    run(5);
    chk("rnd_nframes", rx_q.size(), hs_q.size());
    for (int i = 0; i < rx_q.size() && i < hs_q.size(); i++)
      chk("rnd_word", rx_q[i], hs_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
